// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver and its receive FIFO.
package uart_pkg;

    localparam int unsigned UART_SIZE_DATA       = 8;
    localparam int unsigned UART_FIFO_DEPTH      = 16;
    localparam int unsigned UART_ALMOST_FULL_LVL = 12;
    localparam int unsigned OVER_SAMPLE          = 16;
    localparam int unsigned MID_SAMPLE           = OVER_SAMPLE / 2;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive FIFO bus: write/pop strobes in, popped data and status out.
// o_almost_full exists only when RX_FIFO_ALMOST_FULL_EN is defined.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned SIZE_DATA = UART_SIZE_DATA,
    parameter int unsigned DEPTH     = UART_FIFO_DEPTH
);

    logic                     i_wr_en;
    logic [SIZE_DATA-1:0]     i_wr_data;
    logic                     i_rd_en;
    logic                     i_clr_overrun;
    logic [SIZE_DATA-1:0]     o_rd_data;
    logic                     o_rd_valid;
    logic                     o_full;
    logic                     o_empty;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     o_overrun;
`ifdef RX_FIFO_ALMOST_FULL_EN
    logic                     o_almost_full;
`endif

    modport master (
        output i_wr_en, i_wr_data, i_rd_en, i_clr_overrun,
        input  o_rd_data, o_rd_valid, o_full, o_empty, o_count, o_overrun
`ifdef RX_FIFO_ALMOST_FULL_EN
        , o_almost_full
`endif
    );

    modport slave (
        input  i_wr_en, i_wr_data, i_rd_en, i_clr_overrun,
        output o_rd_data, o_rd_valid, o_full, o_empty, o_count, o_overrun
`ifdef RX_FIFO_ALMOST_FULL_EN
        , o_almost_full
`endif
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module uart_fifo_mem #(
    parameter int unsigned SIZE_DATA = 8,
    parameter int unsigned DEPTH     = 16,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [SIZE_DATA-1:0] i_wr_data,
    input  logic [AW-1:0]        i_rd_addr,
    output logic [SIZE_DATA-1:0] o_rd_data
);

    logic [SIZE_DATA-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: circular buffer with registered pop, sticky overrun and status flags.
// Optional registered almost-full flag enabled by defining RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned SIZE_DATA       = UART_SIZE_DATA,
    parameter int unsigned DEPTH           = UART_FIFO_DEPTH,
    parameter int unsigned ALMOST_FULL_LVL = UART_ALMOST_FULL_LVL
) (
    input logic           i_clk,
    input logic           i_rst_n,
    uart_rx_fifo_if.slave bus
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam int unsigned   CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two, at least 4");
    end
    if (ALMOST_FULL_LVL < 1 || ALMOST_FULL_LVL >= DEPTH) begin : g_bad_lvl
        $error("uart_rx_fifo: ALMOST_FULL_LVL must be in 1..DEPTH-1");
    end

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [SIZE_DATA-1:0] rd_data_q, rd_data_d, mem_rd_data;
    logic                 rd_valid_q, overrun_q, overrun_d;
    logic                 full, empty, pop, push;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign pop   = bus.i_rd_en && !empty;
    // A pop frees the slot the same edge, so a full FIFO can still take a write.
    assign push  = bus.i_wr_en && (!full || pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        overrun_d = overrun_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem_rd_data;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (bus.i_clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (bus.i_wr_en && !push) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= pop;
            overrun_q  <= overrun_d;
        end
    end

    uart_fifo_mem #(
        .SIZE_DATA (SIZE_DATA),
        .DEPTH     (DEPTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (push),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (bus.i_wr_data),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (mem_rd_data)
    );

    assign bus.o_rd_data  = rd_data_q;
    assign bus.o_rd_valid = rd_valid_q;
    assign bus.o_full     = full;
    assign bus.o_empty    = empty;
    assign bus.o_count    = count_q;
    assign bus.o_overrun  = overrun_q;

`ifdef RX_FIFO_ALMOST_FULL_EN
    localparam logic [CW-1:0] AF_LVL = CW'(ALMOST_FULL_LVL);
    logic almost_full_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (count_d >= AF_LVL);
        end
    end

    assign bus.o_almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a reference queue predicts every popped character.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] model_q [$];
    logic [7:0] exp_q [$];

    uart_rx_fifo_if #(.SIZE_DATA(8), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .SIZE_DATA       (8),
        .DEPTH           (DEPTH),
        .ALMOST_FULL_LVL (12)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest predicted character.
    always @(negedge clk) begin
        if (rst_n && bus.o_rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", int'(bus.o_rd_data), -1);
            end else begin
                chk("rd_data", int'(bus.o_rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic xfer(input bit w, input bit r, input logic [7:0] d);
        bit pop_ok, wr_ok;
        pop_ok = r && (model_q.size() > 0);
        wr_ok  = w && ((model_q.size() < DEPTH) || pop_ok);
        if (pop_ok) exp_q.push_back(model_q.pop_front());
        if (wr_ok) model_q.push_back(d);
        bus.i_wr_en   = w;
        bus.i_rd_en   = r;
        bus.i_wr_data = d;
        @(posedge clk);
        #1;
        bus.i_wr_en = 1'b0;
        bus.i_rd_en = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) xfer(1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        bus.i_wr_en       = 1'b0;
        bus.i_rd_en       = 1'b0;
        bus.i_wr_data     = '0;
        bus.i_clr_overrun = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(bus.o_count), 0);
        chk("rst_empty", int'(bus.o_empty), 1);
        chk("rst_full", int'(bus.o_full), 0);
        chk("rst_rd_valid", int'(bus.o_rd_valid), 0);
        chk("rst_rd_data", int'(bus.o_rd_data), 0);
        chk("rst_overrun", int'(bus.o_overrun), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write then pop with one-cycle latency
        xfer(1'b1, 1'b0, 8'hA5);
        chk("one_count", int'(bus.o_count), 1);
        xfer(1'b0, 1'b1, 8'h00);
        chk("pop_valid_latency", int'(bus.o_rd_valid), 1);
        chk("pop_data_latency", int'(bus.o_rd_data), 'hA5);
        chk("pop_empty", int'(bus.o_empty), 1);
        xfer(1'b0, 1'b0, 8'h00);
        chk("valid_one_cycle", int'(bus.o_rd_valid), 0);

        // Fill, drain in order, then wrap
        for (int i = 0; i < 16; i++) xfer(1'b1, 1'b0, 8'(i));
        chk("fill_full", int'(bus.o_full), 1);
        chk("fill_count", int'(bus.o_count), 16);
        drain(16);
        chk("drain_empty", int'(bus.o_empty), 1);
        for (int i = 16; i < 20; i++) xfer(1'b1, 1'b0, 8'(i));
        chk("wrap_count", int'(bus.o_count), 4);
        drain(4);

        // Overrun: dropped write, sticky, set beats clear
        for (int i = 0; i < 16; i++) xfer(1'b1, 1'b0, 8'(8'h20 + i));
        xfer(1'b1, 1'b0, 8'h55);
        chk("ovr_set", int'(bus.o_overrun), 1);
        chk("ovr_count", int'(bus.o_count), 16);
        xfer(1'b0, 1'b0, 8'h00);
        chk("ovr_sticky", int'(bus.o_overrun), 1);
        bus.i_clr_overrun = 1'b1;
        xfer(1'b1, 1'b0, 8'h66);
        chk("ovr_set_wins", int'(bus.o_overrun), 1);
        xfer(1'b0, 1'b0, 8'h00);
        bus.i_clr_overrun = 1'b0;
        chk("ovr_clear", int'(bus.o_overrun), 0);
        drain(16);

        // Simultaneous write and pop while full
        for (int i = 0; i < 16; i++) xfer(1'b1, 1'b0, 8'(8'h30 + i));
        xfer(1'b1, 1'b1, 8'h77);
        chk("full_wr_pop_count", int'(bus.o_count), 16);
        chk("full_wr_pop_valid", int'(bus.o_rd_valid), 1);
        chk("full_wr_pop_ovr", int'(bus.o_overrun), 0);
        drain(16);

        // Simultaneous write and pop while empty: no bypass
        xfer(1'b1, 1'b1, 8'h88);
        chk("empty_wr_pop_valid", int'(bus.o_rd_valid), 0);
        chk("empty_wr_pop_count", int'(bus.o_count), 1);
        drain(1);

        // Pop while empty is ignored, data holds
        xfer(1'b0, 1'b1, 8'h00);
        chk("empty_pop_valid", int'(bus.o_rd_valid), 0);
        chk("empty_pop_hold", int'(bus.o_rd_data), 'h88);
        chk("empty_pop_count", int'(bus.o_count), 0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 6; i++) xfer(1'b1, 1'b0, 8'(8'h40 + i));
        xfer(1'b0, 1'b1, 8'h00);
        chk("pre_rst_valid", int'(bus.o_rd_valid), 1);
        chk("pre_rst_count", int'(bus.o_count), 5);
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(bus.o_count), 0);
        chk("async_rst_empty", int'(bus.o_empty), 1);
        chk("async_rst_valid", int'(bus.o_rd_valid), 0);
        chk("async_rst_data", int'(bus.o_rd_data), 0);
        exp_q.delete();
        model_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(1'b1, 1'b0, 8'h9C);
        drain(1);

`ifdef RX_FIFO_ALMOST_FULL_EN
        for (int i = 0; i < 11; i++) xfer(1'b1, 1'b0, 8'(8'h60 + i));
        chk("af_11", int'(bus.o_almost_full), 0);
        xfer(1'b1, 1'b0, 8'h6B);
        chk("af_12", int'(bus.o_almost_full), 1);
        xfer(1'b0, 1'b1, 8'h00);
        chk("af_pop", int'(bus.o_almost_full), 0);
        drain(11);
`endif

        repeat (2) xfer(1'b0, 1'b0, 8'h00);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 8, receive character width.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, minimum 4.
REQ-003 SHALL have parameter ALMOST_FULL_LVL, default 12, occupancy at which almost-full asserts; range 1..DEPTH-1.
REQ-004 SHALL have port i_clk, input, 1, single clock for the whole block. One clock domain only.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_wr_en, input, 1, write strobe, driven by the receiver done pulse.
REQ-007 SHALL have port i_wr_data, input, SIZE_DATA, received character to write.
REQ-008 SHALL have port i_rd_en, input, 1, pop request from the consumer.
REQ-009 SHALL have port i_clr_overrun, input, 1, clears the sticky overrun flag.
REQ-010 SHALL have port o_rd_data, output, SIZE_DATA, popped character.
REQ-011 SHALL have port o_rd_valid, output, 1, one-cycle pulse marking o_rd_data as new.
REQ-012 SHALL have port o_full, output, 1, occupancy == DEPTH; feeds the receiver i_fifo_full.
REQ-013 SHALL have port o_empty, output, 1, occupancy == 0.
REQ-014 SHALL have port o_count, output, $clog2(DEPTH)+1, current occupancy.
REQ-015 SHALL have port o_overrun, output, 1, sticky flag marking a dropped write.
REQ-016 SHALL have port o_almost_full, output, 1, present only when RX_FIFO_ALMOST_FULL_EN is defined.

Function
REQ-017 SHALL store entries in a circular buffer.
- Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH.
- A separate occupancy counter drives o_count, o_full and o_empty.
REQ-018 SHALL accept a write when i_wr_en=1 and (o_full=0 or a pop is accepted in the same cycle); the entry is stored at the write pointer, which then increments.
REQ-019 SHALL accept a pop when i_rd_en=1 and o_empty=0.
- On the next edge: o_rd_data is loaded from the read pointer, o_rd_valid=1, and the read pointer increments.
- Read latency is exactly 1 cycle.
REQ-020 SHALL ignore i_rd_en while o_empty=1: no pointer change, o_rd_valid=0, o_rd_data holds.
REQ-021 SHALL hold o_rd_data between pops and drive o_rd_valid=0 in every cycle without an accepted pop.
REQ-022 SHALL update occupancy as follows:
- +1 on write only.
- -1 on pop only.
- Unchanged on simultaneous write and pop.
REQ-023 SHALL handle a simultaneous write and pop while empty with no bypass: the pop is ignored, the write is stored, and occupancy becomes 1.
REQ-024 SHALL handle a simultaneous write and pop while full by accepting both: occupancy stays DEPTH and the oldest entry is output.
REQ-025 SHALL drop a write made while full with no pop, leave memory and pointers untouched, and set o_overrun on the next edge.
REQ-026 SHALL keep o_overrun set until i_clr_overrun=1; when a set condition and the clear coincide, set wins.
REQ-027 SHALL derive o_full, o_empty, o_count and o_almost_full from registered state only, with no combinational path from i_wr_en or i_rd_en.

Reset
REQ-028 SHALL, on i_rst_n=0, asynchronously drive:
- pointers=0, occupancy=0, o_count=0;
- o_empty=1, o_full=0;
- o_rd_data=0, o_rd_valid=0;
- o_overrun=0, o_almost_full=0.
REQ-029 SHALL discard all stored entries on reset asserted mid-operation; memory contents need not be cleared.

Configuration
REQ-030 SHALL, with RX_FIFO_ALMOST_FULL_EN defined, register o_almost_full=1 whenever occupancy >= ALMOST_FULL_LVL.
REQ-031 SHALL, without RX_FIFO_ALMOST_FULL_EN, omit the o_almost_full port and its comparator entirely.

Structure
REQ-032 SHALL take SIZE_DATA default, FIFO DEPTH default and the OVER_SAMPLE/MID_SAMPLE constants from shared package uart_pkg, which the UART receiver also uses.
REQ-033 SHALL place the storage array in sub-module uart_fifo_mem:
- one synchronous write port;
- one asynchronous read port;
- no reset on the array.

Verification
REQ-034 SHALL cover single write then pop: write 0xA5; pop -> o_rd_data=0xA5 with o_rd_valid=1 one cycle after the pop; o_empty=1.
REQ-035 SHALL cover fill and wrap: write 16 values 0x00..0x0F -> o_full=1, o_count=16; pop 16 -> data arrives in order; write 0x10..0x13 -> wrap, read back in order.
REQ-036 SHALL cover overrun: fill to 16, write 0x55 with no pop -> o_overrun=1, 0x55 never read; i_clr_overrun=1 -> o_overrun=0 next cycle.
REQ-037 SHALL cover the simultaneous cases:
- full, write 0x77 + pop -> first entry output, o_count stays 16, 0x77 read last;
- empty, write + pop -> o_rd_valid=0, o_count=1.
REQ-038 SHALL cover reset mid-operation: 5 entries, drop i_rst_n -> o_count=0, o_empty=1, o_rd_valid=0 immediately, without waiting for a clock.
REQ-039 SHALL cover almost-full with the macro defined: 11 writes -> o_almost_full=0; 12th write -> 1; one pop -> 0.
